// File: rtl/fff_round_controller.sv
// fff_round_controller
//   Host-side round controller for the fastest-finger-first buzzer.
//   Arms the player latch, filters the encoded winner code (two identical
//   consecutive valid codes lock the round), lights a one-hot lamp, runs the
//   answer window, applies correct/wrong verdicts to four saturating score
//   counters, and re-arms with per-player lockout after a wrong answer.
//
//   Optional feature macro: FFF_NEG_SCORE_EN
//     defined   -> wrong verdict / timeout decrements the winner's score (floor 0)
//     undefined -> wrong verdict / timeout leave scores unchanged
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        open a new round (sampled in IDLE only)
//   winner_code  0 none, 1-4 player, 5-7 invalid
//   correct      verdict pulse: correct (wins over wrong)
//   wrong        verdict pulse: wrong
//   latch_en     1 = player latch armed/transparent
//   lamp         one-hot winner lamp, bit n-1 = player n
//   timeout      one-cycle pulse on answer-window expiry
//   locked_out   per-player lockout mask for the round
//   score        packed scores, player n at [n*SCORE_W-1 : (n-1)*SCORE_W]
//   state        0 IDLE, 1 ARMED, 2 LOCKED
module fff_round_controller #(
  parameter int ANSWER_CYCLES = 1000,
  parameter int SCORE_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           winner_code,
  input  logic                 correct,
  input  logic                 wrong,
  output logic                 latch_en,
  output logic [3:0]           lamp,
  output logic                 timeout,
  output logic [3:0]           locked_out,
  output logic [4*SCORE_W-1:0] score,
  output logic [1:0]           state
);

  localparam int TW = $clog2(ANSWER_CYCLES + 1);
  localparam logic [TW-1:0]      TLOAD = TW'(ANSWER_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SMAX  = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_LOCKED = 2'd2} st_t;

  st_t               st;
  logic [2:0]        filt;
  logic [TW-1:0]     timer;
  logic [SCORE_W-1:0] sc [4];

  logic [3:0] code_oh;
  logic [2:0] cand;
  logic [3:0] lo_next;
  logic       expire;

  assign state = st;

  for (genvar g = 0; g < 4; g++) begin : g_score
    assign score[g*SCORE_W +: SCORE_W] = sc[g];
  end

  always_comb begin
    code_oh = 4'b0000;
    case (winner_code)
      3'd1:    code_oh = 4'b0001;
      3'd2:    code_oh = 4'b0010;
      3'd3:    code_oh = 4'b0100;
      3'd4:    code_oh = 4'b1000;
      default: code_oh = 4'b0000;
    endcase
    // Only unlocked players count; anything else reads as "no candidate".
    cand = (|(code_oh & ~locked_out)) ? winner_code : 3'd0;
  end

  // Timer was loaded with ANSWER_CYCLES-1 on lock; the window closes on the
  // edge where it would reach zero, giving expiry ANSWER_CYCLES-1 edges later.
  assign expire  = (timer == TW'(1));
  assign lo_next = locked_out | lamp;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      latch_en   <= 1'b0;
      lamp       <= 4'b0000;
      timeout    <= 1'b0;
      locked_out <= 4'b0000;
      filt       <= 3'd0;
      timer      <= '0;
      for (int i = 0; i < 4; i++) sc[i] <= '0;
    end else begin
      timeout <= 1'b0;
      case (st)
        S_IDLE: begin
          latch_en <= 1'b0;
          lamp     <= 4'b0000;
          if (start) begin
            st         <= S_ARMED;
            latch_en   <= 1'b1;
            locked_out <= 4'b0000;
            filt       <= 3'd0;
          end
        end
        S_ARMED: begin
          filt <= cand;
          if (cand != 3'd0 && cand == filt) begin
            st       <= S_LOCKED;
            latch_en <= 1'b0;
            lamp     <= code_oh;
            timer    <= TLOAD;
            filt     <= 3'd0;
          end
        end
        S_LOCKED: begin
          if (timer != '0) timer <= timer - 1'b1;
          if (correct) begin
            for (int i = 0; i < 4; i++)
              if (lamp[i] && sc[i] != SMAX) sc[i] <= sc[i] + 1'b1;
            st       <= S_IDLE;
            lamp     <= 4'b0000;
            latch_en <= 1'b0;
          end else if (wrong || expire) begin
            timeout    <= ~wrong;
            locked_out <= lo_next;
`ifdef FFF_NEG_SCORE_EN
            for (int i = 0; i < 4; i++)
              if (lamp[i] && sc[i] != '0) sc[i] <= sc[i] - 1'b1;
`endif
            lamp <= 4'b0000;
            filt <= 3'd0;
            if (&lo_next) begin
              st       <= S_IDLE;
              latch_en <= 1'b0;
            end else begin
              st       <= S_ARMED;
              latch_en <= 1'b1;
            end
          end
        end
        default: begin
          st       <= S_IDLE;
          latch_en <= 1'b0;
          lamp     <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fff_round_controller.sv
module tb_fff_round_controller;

  localparam int AC = 5;
  localparam int SW = 4;

  logic        clk = 1'b0;
  logic        rst, start, correct, wrong;
  logic [2:0]  winner_code;
  logic        latch_en, timeout;
  logic [3:0]  lamp, locked_out;
  logic [15:0] score;
  logic [1:0]  state;

  int nchk = 0;
  int nerr = 0;

  fff_round_controller #(.ANSWER_CYCLES(AC), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .winner_code(winner_code),
    .correct(correct), .wrong(wrong), .latch_en(latch_en), .lamp(lamp),
    .timeout(timeout), .locked_out(locked_out), .score(score), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start;
    logic [2:0]  code;
    logic        cor, wr;
    logic [1:0]  st;
    logic        le;
    logic [3:0]  lamp;
    logic        to;
    logic [3:0]  lo;
    logic [15:0] sc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic [2:0] c, input logic co,
                     input logic w, input logic [1:0] st, input logic le,
                     input logic [3:0] lm, input logic to, input logic [3:0] lo,
                     input logic [15:0] sc);
    vec_t v;
    v.rst = r; v.start = s; v.code = c; v.cor = co; v.wr = w;
    v.st = st; v.le = le; v.lamp = lm; v.to = to; v.lo = lo; v.sc = sc;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic [2:0] c,
                      input logic co, input logic w);
    rst = r; start = s; winner_code = c; correct = co; wrong = w;
    @(posedge clk);
    #1;
  endtask

  task automatic round_p1_correct();
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
  endtask

  logic [15:0] sc_p2drop, sc_all;

  initial begin
    rst = 1; start = 0; winner_code = 0; correct = 0; wrong = 0;

`ifdef FFF_NEG_SCORE_EN
    sc_p2drop = 16'h0100;
    sc_all    = 16'h0000;
`else
    sc_p2drop = 16'h0110;
    sc_all    = 16'h0110;
`endif

    //   rst st code co wr | state le lamp to lo score
    add(1, 0, 0, 0, 0,   0, 0, 4'b0000, 0, 4'b0000, 16'h0000); // 0 reset
    add(0, 1, 0, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0000); // 1 start
    add(0, 0, 3, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0000); // 2
    add(0, 0, 3, 0, 0,   2, 0, 4'b0100, 0, 4'b0000, 16'h0000); // 3 lock P3
    add(0, 0, 0, 1, 0,   0, 0, 4'b0000, 0, 4'b0000, 16'h0100); // 4 correct
    add(0, 1, 0, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0100); // 5
    add(0, 0, 2, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0100); // 6 glitch
    add(0, 0, 0, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0100); // 7
    add(0, 0, 2, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0100); // 8
    add(0, 0, 0, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0100); // 9
    add(0, 0, 2, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0100); // 10
    add(0, 0, 2, 0, 0,   2, 0, 4'b0010, 0, 4'b0000, 16'h0100); // 11 lock P2
    add(0, 0, 0, 1, 1,   0, 0, 4'b0000, 0, 4'b0000, 16'h0110); // 12 both verdicts
    add(0, 1, 0, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0110); // 13
    add(0, 0, 1, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, 16'h0110); // 14
    add(0, 0, 1, 0, 0,   2, 0, 4'b0001, 0, 4'b0000, 16'h0110); // 15 lock P1 (L)
    add(0, 0, 0, 0, 0,   2, 0, 4'b0001, 0, 4'b0000, 16'h0110); // 16
    add(0, 0, 0, 0, 0,   2, 0, 4'b0001, 0, 4'b0000, 16'h0110); // 17
    add(0, 0, 0, 0, 0,   2, 0, 4'b0001, 0, 4'b0000, 16'h0110); // 18
    add(0, 0, 0, 0, 0,   1, 1, 4'b0000, 1, 4'b0001, 16'h0110); // 19 L+4 timeout
    add(0, 0, 1, 0, 0,   1, 1, 4'b0000, 0, 4'b0001, 16'h0110); // 20 locked P1
    add(0, 0, 1, 0, 0,   1, 1, 4'b0000, 0, 4'b0001, 16'h0110); // 21
    add(0, 0, 4, 0, 0,   1, 1, 4'b0000, 0, 4'b0001, 16'h0110); // 22
    add(0, 0, 4, 0, 0,   2, 0, 4'b1000, 0, 4'b0001, 16'h0110); // 23 lock P4
    add(0, 0, 0, 0, 1,   1, 1, 4'b0000, 0, 4'b1001, 16'h0110); // 24 wrong P4
    add(0, 0, 2, 0, 0,   1, 1, 4'b0000, 0, 4'b1001, 16'h0110); // 25
    add(0, 0, 2, 0, 0,   2, 0, 4'b0010, 0, 4'b1001, 16'h0110); // 26
    add(0, 0, 0, 0, 1,   1, 1, 4'b0000, 0, 4'b1011, sc_p2drop); // 27 wrong P2
    add(0, 0, 3, 0, 0,   1, 1, 4'b0000, 0, 4'b1011, sc_p2drop); // 28
    add(0, 0, 3, 0, 0,   2, 0, 4'b0100, 0, 4'b1011, sc_p2drop); // 29
    add(0, 0, 0, 0, 1,   0, 0, 4'b0000, 0, 4'b1111, sc_all);    // 30 all locked
    add(0, 1, 7, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, sc_all);    // 31 restart
    add(0, 0, 7, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, sc_all);    // 32 invalid code
    add(0, 0, 7, 0, 0,   1, 1, 4'b0000, 0, 4'b0000, sc_all);    // 33

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].start, vq[i].code, vq[i].cor, vq[i].wr);
      chk($sformatf("row%0d.state", i), {14'd0, state},       {14'd0, vq[i].st});
      chk($sformatf("row%0d.latch", i), {15'd0, latch_en},    {15'd0, vq[i].le});
      chk($sformatf("row%0d.lamp", i),  {12'd0, lamp},        {12'd0, vq[i].lamp});
      chk($sformatf("row%0d.tmo", i),   {15'd0, timeout},     {15'd0, vq[i].to});
      chk($sformatf("row%0d.lock", i),  {12'd0, locked_out},  {12'd0, vq[i].lo});
      chk($sformatf("row%0d.score", i), score,                vq[i].sc);
    end

    // Verdict on the expiry edge wins: no timeout pulse, score counts.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("exp.lock", {14'd0, state}, 16'd2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("exp.still_locked", {14'd0, state}, 16'd2);
    step(0, 0, 0, 1, 0);
    chk("exp.no_timeout", {15'd0, timeout}, 16'd0);
    chk("exp.state", {14'd0, state}, 16'd0);
    chk("exp.p1", {12'd0, score[3:0]}, 16'd1);

    // P1 saturation at 15.
    for (int r = 0; r < 13; r++) round_p1_correct();
    chk("sat.p1_14", {12'd0, score[3:0]}, 16'd14);
    round_p1_correct();
    chk("sat.p1_15", {12'd0, score[3:0]}, 16'd15);
    round_p1_correct();
    chk("sat.p1_hold", {12'd0, score[3:0]}, 16'd15);
    chk("sat.others", {4'd0, score[15:4]}, {4'd0, sc_all[15:4]});

    // Reset in the middle of a locked round.
    step(0, 1, 0, 0, 0);
    step(0, 0, 2, 0, 0);
    step(0, 0, 2, 0, 0);
    chk("rst.pre_state", {14'd0, state}, 16'd2);
    step(1, 0, 2, 0, 0);
    chk("rst.state", {14'd0, state}, 16'd0);
    chk("rst.latch", {15'd0, latch_en}, 16'd0);
    chk("rst.lamp", {12'd0, lamp}, 16'd0);
    chk("rst.tmo", {15'd0, timeout}, 16'd0);
    chk("rst.lock", {12'd0, locked_out}, 16'd0);
    chk("rst.score", score, 16'h0000);
    step(0, 0, 0, 1, 1);
    chk("rst.idle_verdict", {14'd0, state}, 16'd0);
    chk("rst.idle_score", score, 16'h0000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
